// File: rtl/char_overlay_pkg.sv
// char_overlay_pkg
// Shared constants for the character overlay: colour constants and the glyph
// code map understood by char_glyph_rom.
//   BLACK / WHITE : 24-bit RGB888 colours
//   GLYPH_*       : codes of the Chinese labels; codes 0-9 are the digits
package char_overlay_pkg;

   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [23:0] WHITE = 24'hFFFFFF;

   // Codes 0..9 render the decimal digit of the same value.
   localparam logic [7:0] GLYPH_HONG  = 8'd10; // red
   localparam logic [7:0] GLYPH_LV    = 8'd11; // green
   localparam logic [7:0] GLYPH_JIN   = 8'd12; // near
   localparam logic [7:0] GLYPH_ZHONG = 8'd13; // middle
   localparam logic [7:0] GLYPH_YUAN  = 8'd14; // far
   localparam logic [7:0] GLYPH_WU    = 8'd15; // none

endpackage

// File: rtl/char_glyph_rom.sv
// char_glyph_rom
// Glyph table with a registered one-cycle read of one glyph row.
//   clk, rst : clock, synchronous active-high reset (clears the read register)
//   code     : glyph code (unknown codes read as an all-zero row)
//   row      : glyph row within the cell
//   row_bits : CHAR_W pixels of the addressed row, MSB = leftmost pixel
// Glyphs are drawn from seven bar segments laid out in a 16x32 cell; the
// Chinese labels use distinct segment shapes so each stays recognisable.
module char_glyph_rom
   import char_overlay_pkg::*;
#(
   parameter int CHAR_W = 16,
   parameter int ROW_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        code,
   input  logic [ROW_W-1:0]  row,
   output logic [CHAR_W-1:0] row_bits
);

   // Segment bits: 0=top, 1=upper right, 2=lower right, 3=bottom,
   // 4=lower left, 5=upper left, 6=middle.
   function automatic logic [6:0] seg_mask(input logic [7:0] c);
      case (c)
         8'd0:        return 7'h3F;
         8'd1:        return 7'h06;
         8'd2:        return 7'h5B;
         8'd3:        return 7'h4F;
         8'd4:        return 7'h66;
         8'd5:        return 7'h6D;
         8'd6:        return 7'h7D;
         8'd7:        return 7'h07;
         8'd8:        return 7'h7F;
         8'd9:        return 7'h6F;
         GLYPH_HONG:  return 7'h77;
         GLYPH_LV:    return 7'h7C;
         GLYPH_JIN:   return 7'h39;
         GLYPH_ZHONG: return 7'h5E;
         GLYPH_YUAN:  return 7'h79;
         GLYPH_WU:    return 7'h71;
         default:     return 7'h00;
      endcase
   endfunction

   function automatic logic [CHAR_W-1:0] glyph_row(input logic [7:0] c, input int r);
      logic [6:0]        m;
      logic [CHAR_W-1:0] b;
      int                r0, r1, c0, c1;
      m = seg_mask(c);
      b = '0;
      for (int s = 0; s < 7; s++) begin
         case (s)
            1:       begin r0 = 2;  r1 = 16; c0 = 11; c1 = 13; end
            2:       begin r0 = 15; r1 = 29; c0 = 11; c1 = 13; end
            3:       begin r0 = 27; r1 = 29; c0 = 3;  c1 = 12; end
            4:       begin r0 = 15; r1 = 29; c0 = 2;  c1 = 4;  end
            5:       begin r0 = 2;  r1 = 16; c0 = 2;  c1 = 4;  end
            6:       begin r0 = 15; r1 = 16; c0 = 3;  c1 = 12; end
            default: begin r0 = 2;  r1 = 4;  c0 = 3;  c1 = 12; end
         endcase
         if (m[s] && r >= r0 && r <= r1) begin
            for (int col = 0; col < CHAR_W; col++) begin
               if (col >= c0 && col <= c1) b[CHAR_W-1-col] = 1'b1;
            end
         end
      end
      return b;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) row_bits <= '0;
      else     row_bits <= glyph_row(code, int'(row));
   end

endmodule

// File: rtl/char_overlay.sv
// char_overlay
// Draws a string of CHAR_NUM glyphs (optionally on an opaque box, with per-slot
// blinking) over an RGB888 video stream. Fixed two-cycle latency.
//   clk, rst                  : clock, synchronous active-high reset
//   hsycn_i, vsync_i, de_i    : input line sync, frame valid, pixel valid
//   data_i                    : input pixel
//   char_idx                  : glyph codes, slot k in bits [8k+7:8k], slot 0 leftmost
//   pos_x, pos_y              : string top-left coordinate
//   fg_color, bg_color, bg_en : glyph colour, box colour, opaque box enable
//   blink_en                  : per-slot blink enable
//   hsycn_o, vsync_o, de_o, data_o : overlaid video, inputs delayed by 2
module char_overlay
   import char_overlay_pkg::*;
#(
   parameter int HREF         = 640,
   parameter int VSYNC        = 480,
   parameter int CHAR_NUM     = 4,
   parameter int CHAR_W       = 16,
   parameter int CHAR_H       = 32,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hsycn_i,
   input  logic                  vsync_i,
   input  logic                  de_i,
   input  logic [23:0]           data_i,
   input  logic [8*CHAR_NUM-1:0] char_idx,
   input  logic [10:0]           pos_x,
   input  logic [9:0]            pos_y,
   input  logic [23:0]           fg_color,
   input  logic [23:0]           bg_color,
   input  logic                  bg_en,
   input  logic [CHAR_NUM-1:0]   blink_en,
   output logic                  hsycn_o,
   output logic                  vsync_o,
   output logic                  de_o,
   output logic [23:0]           data_o
);

   localparam int SLOT_W = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
   localparam int COL_W  = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
   localparam int ROW_W  = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
   localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [11:0] CW12    = 12'(CHAR_W);
   localparam logic [11:0] STR_W12 = 12'(CHAR_NUM * CHAR_W);
   localparam logic [11:0] CH12    = 12'(CHAR_H);
   localparam logic [11:0] HREF12  = 12'(HREF);
   localparam logic [11:0] VSYNC12 = 12'(VSYNC);

   logic [10:0] x_cnt;
   logic [9:0]  y_cnt;
   logic        vs_d, armed, blink_phase;
   logic [FC_W-1:0] frame_cnt;

   logic [8*CHAR_NUM-1:0] char_idx_s;
   logic [10:0]           pos_x_s;
   logic [9:0]            pos_y_s;
   logic [23:0]           fg_s, bg_s;
   logic                  bg_en_s;
   logic [CHAR_NUM-1:0]   blink_s;

   // Raster position of the current pixel, counted only inside vsync_i.
   always_ff @(posedge clk) begin
      if (rst || !vsync_i) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (de_i) begin
         if (x_cnt == 11'(HREF - 1)) begin
            x_cnt <= '0;
            if (y_cnt != 10'(VSYNC - 1)) y_cnt <= y_cnt + 10'd1;
         end else begin
            x_cnt <= x_cnt + 11'd1;
         end
      end
   end

   // armed: a blanking interval has been seen since reset, so the counters are
   // aligned to a real frame start. Frames cut by a reset are neither drawn
   // nor counted towards the blink period.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d        <= 1'b0;
         armed       <= 1'b0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         vs_d <= vsync_i;
         if (!vsync_i) armed <= 1'b1;
         if (vs_d && !vsync_i && armed) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Settings follow the inputs during blanking and stay frozen for the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         char_idx_s <= '0;
         pos_x_s    <= '0;
         pos_y_s    <= '0;
         fg_s       <= BLACK;
         bg_s       <= BLACK;
         bg_en_s    <= 1'b0;
         blink_s    <= '0;
      end else if (!vsync_i) begin
         char_idx_s <= char_idx;
         pos_x_s    <= pos_x;
         pos_y_s    <= pos_y;
         fg_s       <= fg_color;
         bg_s       <= bg_color;
         bg_en_s    <= bg_en;
         blink_s    <= blink_en;
      end
   end

   // Window test at 12 bits: the right/bottom edges cannot overflow, and the
   // parts past the active area are clipped instead of wrapping.
   logic [11:0] x12, y12, px12, py12, dx, dy;
   logic        in_x, in_y, in_win;
   logic [SLOT_W-1:0] slot;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [7:0]        code;

   assign x12    = {1'b0, x_cnt};
   assign y12    = {2'b0, y_cnt};
   assign px12   = {1'b0, pos_x_s};
   assign py12   = {2'b0, pos_y_s};
   assign in_x   = (x12 >= px12) && (x12 < px12 + STR_W12) && (x12 < HREF12);
   assign in_y   = (y12 >= py12) && (y12 < py12 + CH12) && (y12 < VSYNC12);
   assign in_win = armed && vsync_i && de_i && in_x && in_y;
   assign dx     = x12 - px12;
   assign dy     = y12 - py12;
   assign slot   = SLOT_W'(dx / CW12);
   assign col    = COL_W'(dx % CW12);
   assign row    = ROW_W'(dy);

   always_comb begin
      code = 8'd0;
      for (int k = 0; k < CHAR_NUM; k++) begin
         if (slot == SLOT_W'(k)) code = char_idx_s[8*k +: 8];
      end
   end

   logic [CHAR_W-1:0] rom_row;

   char_glyph_rom #(.CHAR_W(CHAR_W), .ROW_W(ROW_W)) u_rom (
      .clk      (clk),
      .rst      (rst),
      .code     (code),
      .row      (row),
      .row_bits (rom_row)
   );

   // Stage 1 carries everything the stage-2 mux needs, including the colours,
   // so a shadow update right after the last pixel cannot affect that pixel.
   logic             hs1, vs1, de1, win1, vis1, bgen1;
   logic [23:0]      data1, fg1, bg1;
   logic [COL_W-1:0] col1;
   logic             glyph_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs1   <= 1'b0;
         vs1   <= 1'b0;
         de1   <= 1'b0;
         data1 <= BLACK;
         win1  <= 1'b0;
         col1  <= '0;
         vis1  <= 1'b0;
         bgen1 <= 1'b0;
         fg1   <= BLACK;
         bg1   <= BLACK;
      end else begin
         hs1   <= hsycn_i;
         vs1   <= vsync_i;
         de1   <= de_i;
         data1 <= data_i;
         win1  <= in_win;
         col1  <= col;
         vis1  <= ~(blink_s[slot] & blink_phase);
         bgen1 <= bg_en_s;
         fg1   <= fg_s;
         bg1   <= bg_s;
      end
   end

   assign glyph_bit = rom_row[COL_W'(CHAR_W - 1) - col1];

   always_ff @(posedge clk) begin
      if (rst) begin
         hsycn_o <= 1'b0;
         vsync_o <= 1'b0;
         de_o    <= 1'b0;
         data_o  <= BLACK;
      end else begin
         hsycn_o <= hs1;
         vsync_o <= vs1;
         de_o    <= de1;
         if (win1 && vis1 && glyph_bit) data_o <= fg1;
         else if (win1 && bgen1)        data_o <= bg1;
         else                           data_o <= data1;
      end
   end

endmodule

// File: tb/tb_char_overlay.sv
// tb_char_overlay
// Randomised video through char_overlay against a pixel-level reference model:
// the driver knows each pixel's (x, y); the model tests it against the string
// box, looks the pixel up in a segment-rectangle description of the font and
// derives the blink phase from the number of completed frames.
module tb_char_overlay;
   import char_overlay_pkg::*;

   localparam int HREF         = 128;
   localparam int VSYNC        = 220;
   localparam int CHAR_NUM     = 4;
   localparam int CHAR_W       = 16;
   localparam int CHAR_H       = 32;
   localparam int BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsycn_i, vsync_i, de_i;
   logic [23:0] data_i;
   logic [31:0] char_idx;
   logic [10:0] pos_x;
   logic [9:0]  pos_y;
   logic [23:0] fg_color, bg_color;
   logic        bg_en;
   logic [3:0]  blink_en;
   logic        hsycn_o, vsync_o, de_o;
   logic [23:0] data_o;

   char_overlay #(
      .HREF(HREF), .VSYNC(VSYNC), .CHAR_NUM(CHAR_NUM), .CHAR_W(CHAR_W),
      .CHAR_H(CHAR_H), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .hsycn_i(hsycn_i), .vsync_i(vsync_i), .de_i(de_i),
      .data_i(data_i), .char_idx(char_idx), .pos_x(pos_x), .pos_y(pos_y),
      .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en), .blink_en(blink_en),
      .hsycn_o(hsycn_o), .vsync_o(vsync_o), .de_o(de_o), .data_o(data_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   typedef struct packed {
      logic [31:0] idx;
      logic [10:0] px;
      logic [9:0]  py;
      logic [23:0] fg;
      logic [23:0] bg;
      logic        bgen;
      logic [3:0]  blink;
   } cfg_t;

   cfg_t        cfg;
   logic [26:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          frames_done = 0;
   bit          frame_valid = 0;
   bit          prev_vs = 0;
   string       tag = "reset";

   task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got {hs,vs,de,data}=%h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Font: digit d lights the seven-segment bars of d; codes 10..15 light the
   // bars of hex A..F; anything else is blank.
   function automatic logic [6:0] font_segs(input logic [7:0] code);
      case (code)
         8'd0: return 7'h3F;  8'd1: return 7'h06;  8'd2: return 7'h5B;  8'd3: return 7'h4F;
         8'd4: return 7'h66;  8'd5: return 7'h6D;  8'd6: return 7'h7D;  8'd7: return 7'h07;
         8'd8: return 7'h7F;  8'd9: return 7'h6F;  8'd10: return 7'h77; 8'd11: return 7'h7C;
         8'd12: return 7'h39; 8'd13: return 7'h5E; 8'd14: return 7'h79; 8'd15: return 7'h71;
         default: return 7'h00;
      endcase
   endfunction

   // Bar rectangles in the 16x32 cell (column, row ranges inclusive).
   function automatic bit in_bar(input int s, input int c, input int r);
      case (s)
         0: return r >= 2  && r <= 4  && c >= 3  && c <= 12;
         1: return r >= 2  && r <= 16 && c >= 11 && c <= 13;
         2: return r >= 15 && r <= 29 && c >= 11 && c <= 13;
         3: return r >= 27 && r <= 29 && c >= 3  && c <= 12;
         4: return r >= 15 && r <= 29 && c >= 2  && c <= 4;
         5: return r >= 2  && r <= 16 && c >= 2  && c <= 4;
         default: return r >= 15 && r <= 16 && c >= 3 && c <= 12;
      endcase
   endfunction

   function automatic bit glyph_on(input logic [7:0] code, input int c, input int r);
      logic [6:0] segs;
      segs = font_segs(code);
      for (int s = 0; s < 7; s++) if (segs[s] && in_bar(s, c, r)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [23:0] pix_exp(input int x, input int y, input logic [23:0] d);
      int px, py, slot, c, r;
      bit on, hidden;
      px = int'(cfg.px);
      py = int'(cfg.py);
      if (x < px || x >= px + CHAR_NUM * CHAR_W || x >= HREF) return d;
      if (y < py || y >= py + CHAR_H || y >= VSYNC) return d;
      slot   = (x - px) / CHAR_W;
      c      = (x - px) % CHAR_W;
      r      = y - py;
      on     = glyph_on(cfg.idx[8*slot +: 8], c, r);
      hidden = cfg.blink[slot] && (((frames_done / BLINK_FRAMES) % 2) == 1);
      if (on && !hidden) return cfg.fg;
      if (cfg.bgen) return cfg.bg;
      return d;
   endfunction

   // ---------------- driver tasks ----------------
   // One clock of stimulus; (x, y) is the raster position of a de=1 pixel.
   task automatic tick(input logic hs, input logic vs, input logic de,
                       input logic [23:0] d, input int x, input int y);
      logic [23:0] ed;
      hsycn_i = hs; vsync_i = vs; de_i = de; data_i = d;
      if (!vs) begin
         if (prev_vs && frame_valid) frames_done++;
         frame_valid = 1'b1;
         cfg = '{idx: char_idx, px: pos_x, py: pos_y, fg: fg_color, bg: bg_color,
                 bgen: bg_en, blink: blink_en};
      end
      prev_vs = vs;
      ed = (vs && de && frame_valid) ? pix_exp(x, y, d) : d;
      exp_q.push_back({hs, vs, de, ed});
      @(posedge clk);
      #1;
      if (exp_q.size() == 2) check(tag, {hsycn_o, vsync_o, de_o, data_o}, exp_q.pop_front());
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) tick(1'(i % 2), 1'b0, 1'b0, 24'($urandom), 0, 0);
   endtask

   task automatic drive_line(input int ln);
      int y;
      y = (ln < VSYNC) ? ln : VSYNC - 1;
      for (int x = 0; x < HREF; x++) begin
         if ($urandom_range(0, 15) == 0) tick(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
         tick(1'b0, 1'b1, 1'b1, 24'($urandom), x, y);
      end
      tick(1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
      tick(1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
      tick(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
   endtask

   task automatic drive_lines(input int first, input int last);
      for (int ln = first; ln <= last; ln++) drive_line(ln);
   endtask

   task automatic do_reset(input int n, input logic hold_vs);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         hsycn_i = 1'($urandom);
         vsync_i = hold_vs ? 1'b1 : 1'($urandom);
         de_i    = 1'($urandom);
         data_i  = 24'($urandom);
         @(posedge clk);
         #1;
         check("reset", {hsycn_o, vsync_o, de_o, data_o}, 27'd0);
      end
      rst = 1'b0;
      exp_q.delete();
      frames_done = 0;
      frame_valid = 1'b0;
      prev_vs     = 1'b0;
   endtask

   task automatic set_cfg(input logic [31:0] idx, input int px, input int py,
                          input logic [23:0] fg, input logic [23:0] bg,
                          input logic be, input logic [3:0] bl);
      char_idx = idx; pos_x = 11'(px); pos_y = 10'(py);
      fg_color = fg; bg_color = bg; bg_en = be; blink_en = bl;
   endtask

   function automatic logic [31:0] rand_digits();
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[8*k +: 8] = 8'($urandom_range(0, 15));
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; hsycn_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0; data_i = '0;
      set_cfg('0, 0, 0, BLACK, BLACK, 1'b0, 4'b0000);
      do_reset(4, 1'b0);

      // single de pulse outside the string box
      tag = "latency";
      set_cfg({8'd3, 8'd2, 8'd1, 8'd0}, 50, 100, WHITE, BLACK, 1'b0, 4'b0000);
      blank(6);
      tick(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
      tick(1'b0, 1'b1, 1'b1, 24'h123456, 0, 0);
      tick(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
      tick(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
      blank(6);

      // digits 0..3 at (50,100); pos_y moved to 200 mid-frame
      tag = "digits";
      set_cfg({8'd3, 8'd2, 8'd1, 8'd0}, 50, 100, 24'($urandom), 24'($urandom), 1'b0, 4'b0000);
      blank(6);
      drive_lines(0, 109);
      pos_y = 10'd200;
      tag = "shadow";
      drive_lines(110, 139);
      blank(6);
      drive_lines(0, 223);   // box clipped at the bottom, last lines saturate
      blank(6);

      // right-edge clip and line wrap
      tag = "clip";
      set_cfg(rand_digits(), 118, 0, 24'($urandom), 24'($urandom), 1'b1, 4'b0000);
      blank(6);
      drive_lines(0, 3);
      blank(6);

      // opaque box with an unknown code in slot 2
      tag = "opaque";
      set_cfg({8'd5, 8'd200, 8'd7, 8'd1}, 20, 3, 24'($urandom), 24'h0000FF, 1'b1, 4'b0000);
      blank(6);
      drive_lines(0, 36);
      blank(6);

      // random settings
      tag = "random";
      for (int f = 0; f < 3; f++) begin
         set_cfg(rand_digits(), $urandom_range(0, HREF - 1), $urandom_range(0, 20),
                 24'($urandom), 24'($urandom), 1'($urandom), 4'($urandom));
         blank($urandom_range(3, 8));
         drive_lines(0, 23);
      end
      blank(6);

      // reset in the middle of a frame: rest of that frame passes through
      tag = "midreset";
      set_cfg(rand_digits(), 10, 0, 24'($urandom), 24'($urandom), 1'b1, 4'b0000);
      blank(6);
      drive_lines(0, 1);
      do_reset(3, 1'b1);
      drive_lines(2, 5);
      blank(6);
      drive_lines(0, 5);
      blank(6);

      // blink of slot 1 over six frames
      do_reset(2, 1'b0);
      tag = "blink";
      set_cfg({8'd8, 8'd8, 8'd8, 8'd8}, 0, 0, WHITE, BLACK, 1'b0, 4'b0010);
      for (int f = 0; f < 6; f++) begin
         blank(6);
         drive_lines(0, 4);
      end
      blank(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/char_overlay.md
CHAR_OVERLAY -- requirements
Module: char_overlay

Interface
REQ-001 SHALL have parameter HREF, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter VSYNC, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter CHAR_NUM, default 4, meaning number of character slots in one horizontal string.
REQ-004 SHALL have parameter CHAR_W, default 16, meaning glyph width in pixels; CHAR_H, default 32, meaning glyph height in lines.
REQ-005 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per blink half-period.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning the reset: synchronous, active-high.
REQ-008 SHALL have ports hsycn_i, vsync_i, de_i, input, 1 each, meaning line sync, frame valid (high during frame), pixel valid.
REQ-009 SHALL have port data_i, input, 24, meaning RGB888 pixel.
REQ-010 SHALL have port char_idx, input, 8*CHAR_NUM, meaning glyph codes; slot k is bits [8k+7:8k], and slot 0 is leftmost.
REQ-011 SHALL have ports pos_x, input, 11, and pos_y, input, 10, meaning string top-left coordinate.
REQ-012 SHALL have port fg_color, input, 24, meaning glyph colour; bg_color, input, 24, meaning box colour.
REQ-013 SHALL have port bg_en, input, 1, meaning opaque box (1) or transparent background (0).
REQ-014 SHALL have port blink_en, input, CHAR_NUM, meaning per-slot blink enable.
REQ-015 SHALL have ports hsycn_o, vsync_o, de_o, output, 1 each, and data_o, output, 24, meaning the overlaid video.

Function
REQ-016 SHALL keep counters x_cnt (11b) and y_cnt (10b) that clear while vsync_i=0.
REQ-017 SHALL increment x_cnt on each de_i=1 cycle; at x_cnt=HREF-1 it SHALL wrap to 0 and increment y_cnt.
REQ-018 SHALL hold both counters when de_i=0; y_cnt SHALL saturate at VSYNC-1.
REQ-019 SHALL shadow char_idx, pos_x, pos_y, fg_color, bg_color, bg_en and blink_en on every cycle with vsync_i=0, and freeze them while vsync_i=1 (no mid-frame tearing).
REQ-020 SHALL define the window as pos_x <= x_cnt < pos_x+CHAR_NUM*CHAR_W and pos_y <= y_cnt < pos_y+CHAR_H, computed at 12-bit width so it has no overflow.
REQ-021 SHALL clip the window parts lying at or beyond HREF/VSYNC; it SHALL never wrap them to the left or top.
REQ-022 In the window, SHALL compute slot = (x_cnt-pos_x)/CHAR_W, column = (x_cnt-pos_x)%CHAR_W and row = y_cnt-pos_y.
REQ-023 Pipeline stage 1 SHALL issue a synchronous glyph ROM read of (code of slot, row) and register column, slot, in-window flag, data_i and syncs.
REQ-024 Stage 2 SHALL take glyph bit = rom_row[CHAR_W-1-column], where the MSB is the leftmost pixel.
REQ-025 Stage 2 output mux: bit=1 and slot visible gives fg_color; otherwise, if in window and bg_en=1, it gives bg_color; otherwise data_i.
REQ-026 A slot SHALL be visible unless its blink_en bit=1 and blink_phase=1; an invisible slot shows background only.
REQ-027 blink_phase SHALL toggle when a frame counter reaches BLINK_FRAMES-1 on a vsync_i falling edge; the counter then clears.
REQ-028 Latency SHALL be exactly 2 cycles; hsycn_o, vsync_o, de_o and data_o SHALL be the inputs delayed by 2 registers, aligned.
REQ-029 Glyph codes with no ROM entry SHALL read as an all-zero row.

Reset
REQ-030 On rst=1, SHALL clear x_cnt, y_cnt, frame counter, blink_phase, all pipeline registers and all shadow registers to 0.
REQ-031 During reset, outputs SHALL be hsycn_o=0, vsync_o=0, de_o=0 and data_o=24'h000000.
REQ-032 Reset mid-frame SHALL discard the partial frame; overlay SHALL resume at the next vsync_i low-to-high transition.

Structure
REQ-033 SHALL put in package char_overlay_pkg: the colour constants BLACK=24'h000000 and WHITE=24'hFFFFFF, and the glyph code map (0-9 digits; 10 红, 11 绿, 12 近, 13 中, 14 远, 15 无).
REQ-034 SHALL place the glyph table in sub-module char_glyph_rom, with a registered 1-cycle read of CHAR_W bits addressed by {code, row}.

Verification
REQ-035 Digit render: char_idx={8'd3,8'd2,8'd1,8'd0}, pos=(50,100), bg_en=0 -> pixels in x 50..113 and y 100..131 match the ROM rows; all other pixels equal data_i.
REQ-036 Latency: de_i pulse with data_i=24'h123456 outside the window -> data_o=24'h123456 and de_o=1 exactly 2 cycles later.
REQ-037 Clip: pos_x=630, CHAR_NUM=4 -> only x 630..639 are overlaid; x_cnt wraps at 639 with no overlay at x=0..53.
REQ-038 Blink: blink_en=4'b0010, BLINK_FRAMES=2 -> slot 1 is hidden in frames 2-3 and visible in frames 0-1 and 4-5; other slots are always visible.
REQ-039 Shadow: change pos_y 100->200 mid-frame -> the current frame still draws at 100 and the next frame draws at 200.
REQ-040 Opaque/unknown code: bg_en=1, bg_color=24'h0000FF, code 8'd200 -> the whole slot box is 24'h0000FF.
